bram_stream_bridge: RTL

//  Parametrised multi-bank successor to the single-BRAM DMA wrapper. Port A of
//   NUM_BANKS true-dual-port banks is driven by an internal FSM with its own

---
 rtl/bram_stream_bridge.sv | 307 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/bram_stream_bridge.sv
// ============================================================================
// bram_stream_bridge: multi-bank dual-port RAM with a burst DMA FSM on port A
// (stream in / credit-gated stream out) and a direct compute path on port B.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bram_stream_bridge #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BANKS  = 2,
  parameter int RD_LATENCY = 2,
  parameter int LEN_WIDTH  = 16,
  parameter int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  parameter int FIFO_DEPTH = RD_LATENCY + 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [BANK_W-1:0]     cfg_bank,
  input  logic                  wr_start,
  input  logic                  rd_start,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic                  start_err,
  input  logic [BANK_W-1:0]     comp_bank,
  input  logic [ADDR_WIDTH-1:0] comp_addr,
  input  logic [DATA_WIDTH-1:0] comp_din,
  input  logic                  comp_we,
  input  logic                  comp_en,
  output logic [DATA_WIDTH-1:0] comp_dout
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [BANK_W-1:0]     bank_q, bank_d;
  logic [LEN_WIDTH-1:0]  ptr_q, ptr_d;
  logic [LEN_WIDTH-1:0]  pop_cnt_q, pop_cnt_d;
  logic                  done_q, done_d;
  logic                  start_err_q, start_err_d;
  logic [CNT_W-1:0]      in_flight_q, in_flight_d;
  logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;

  logic                  wr_beat, rd_issue, push, pop, credit_ok;
  logic [CNT_W:0]        occupancy;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic                  a_en, a_we;

  logic [DATA_WIDTH-1:0] a_out_data;
  logic                  a_out_vld, a_out_last;

  assign busy      = (state_q != ST_IDLE);
  assign s_ready   = (state_q == ST_WRITE);
  assign done      = done_q;
  assign start_err = start_err_q;

  assign wr_beat   = s_ready && s_valid;
  // Reads in the bank pipeline plus words parked in the FIFO may never
  // exceed the FIFO depth, so backpressure cannot overflow it.
  assign occupancy = {1'b0, in_flight_q} + {1'b0, fifo_cnt_q};
  assign credit_ok = occupancy < (CNT_W + 1)'(FIFO_DEPTH);
  assign rd_issue  = (state_q == ST_READ) && (ptr_q < len_q) && credit_ok;
  assign a_addr    = base_q + ADDR_WIDTH'(ptr_q);
  assign a_en      = wr_beat || rd_issue;
  assign a_we      = wr_beat;

  assign m_valid   = (fifo_cnt_q != '0);
  assign push      = a_out_vld;
  assign pop       = m_valid && m_ready;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    bank_d      = bank_q;
    ptr_d       = ptr_q;
    pop_cnt_d   = pop_cnt_q;
    done_d      = 1'b0;
    start_err_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (wr_start || rd_start) begin
          start_err_d = wr_start && rd_start;
          base_d      = cfg_base_addr;
          len_d       = cfg_len;
          bank_d      = cfg_bank;
          ptr_d       = '0;
          pop_cnt_d   = '0;
          if (cfg_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = wr_start ? ST_WRITE : ST_READ;
          end
        end
      end
      ST_WRITE: begin
        start_err_d = wr_start || rd_start;
        if (wr_beat) begin
          ptr_d = ptr_q + 1'b1;
          if (ptr_q == len_q - 1'b1) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_READ, ST_DRAIN: begin
        start_err_d = wr_start || rd_start;
        if (rd_issue) begin
          ptr_d = ptr_q + 1'b1;
          if (ptr_q == len_q - 1'b1) state_d = ST_DRAIN;
        end
        if (pop) begin
          pop_cnt_d = pop_cnt_q + 1'b1;
          if (pop_cnt_q == len_q - 1'b1) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_flight_d = in_flight_q;
    fifo_cnt_d  = fifo_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    unique case ({rd_issue, push})
      2'b10:   in_flight_d = in_flight_q + CNT_W'(1);
      2'b01:   in_flight_d = in_flight_q - CNT_W'(1);
      default: in_flight_d = in_flight_q;
    endcase
    unique case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      bank_q      <= '0;
      ptr_q       <= '0;
      pop_cnt_q   <= '0;
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
      in_flight_q <= '0;
      fifo_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      bank_q      <= bank_d;
      ptr_q       <= ptr_d;
      pop_cnt_q   <= pop_cnt_d;
      done_q      <= done_d;
      start_err_q <= start_err_d;
      in_flight_q <= in_flight_d;
      fifo_cnt_q  <= fifo_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Output FIFO; the head word is presented directly, gated by m_valid.
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic                  fifo_last_q [FIFO_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
    end else if (push) begin
      fifo_data_q[wr_ptr_q] <= a_out_data;
      fifo_last_q[wr_ptr_q] <= a_out_last;
    end
  end

  assign m_data = m_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign m_last = m_valid && fifo_last_q[rd_ptr_q];

  logic [NUM_BANKS*DATA_WIDTH-1:0] a_rd_flat, b_rd_flat;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] bank_a_q, bank_b_q;
    logic                  a_hit, b_hit;

    assign a_hit = a_en && (bank_q == BANK_W'(b));
    assign b_hit = comp_en && (comp_bank == BANK_W'(b));

    // Port A write is applied last so it wins a same-address collision.
    always_ff @(posedge clk) begin
      if (b_hit && comp_we) mem[comp_addr] <= comp_din;
      if (a_hit && a_we)    mem[a_addr]    <= s_data;
    end

    // Non-blocking reads see pre-write contents: read-first on collision.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        bank_a_q <= '0;
        bank_b_q <= '0;
      end else begin
        if (a_hit && !a_we) bank_a_q <= mem[a_addr];
        if (b_hit)          bank_b_q <= mem[comp_addr];
      end
    end

    assign a_rd_flat[b*DATA_WIDTH +: DATA_WIDTH] = bank_a_q;
    assign b_rd_flat[b*DATA_WIDTH +: DATA_WIDTH] = bank_b_q;
  end

  logic [BANK_W-1:0]     a_sel_q, b_sel_q;
  logic                  a_vld1_q, a_last1_q;
  logic [DATA_WIDTH-1:0] a_s1, b_s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sel_q   <= '0;
      b_sel_q   <= '0;
      a_vld1_q  <= 1'b0;
      a_last1_q <= 1'b0;
    end else begin
      a_vld1_q  <= rd_issue;
      a_last1_q <= rd_issue && (ptr_q == len_q - 1'b1);
      if (rd_issue) a_sel_q <= bank_q;
      if (comp_en)  b_sel_q <= comp_bank;
    end
  end

  assign a_s1 = a_rd_flat[a_sel_q*DATA_WIDTH +: DATA_WIDTH];
  assign b_s1 = b_rd_flat[b_sel_q*DATA_WIDTH +: DATA_WIDTH];

  if (RD_LATENCY == 1) begin : g_lat_one
    assign a_out_data = a_s1;
    assign a_out_vld  = a_vld1_q;
    assign a_out_last = a_last1_q;
    assign comp_dout  = b_s1;
  end else begin : g_lat_pipe
    logic [DATA_WIDTH-1:0] a_pipe_q [RD_LATENCY-1];
    logic [DATA_WIDTH-1:0] b_pipe_q [RD_LATENCY-1];
    logic                  vld_pipe_q [RD_LATENCY-1];
    logic                  last_pipe_q [RD_LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < RD_LATENCY - 1; i++) begin
          a_pipe_q[i]    <= '0;
          b_pipe_q[i]    <= '0;
          vld_pipe_q[i]  <= 1'b0;
          last_pipe_q[i] <= 1'b0;
        end
      end else begin
        a_pipe_q[0]    <= a_s1;
        b_pipe_q[0]    <= b_s1;
        vld_pipe_q[0]  <= a_vld1_q;
        last_pipe_q[0] <= a_last1_q;
        for (int i = 1; i < RD_LATENCY - 1; i++) begin
          a_pipe_q[i]    <= a_pipe_q[i-1];
          b_pipe_q[i]    <= b_pipe_q[i-1];
          vld_pipe_q[i]  <= vld_pipe_q[i-1];
          last_pipe_q[i] <= last_pipe_q[i-1];
        end
      end
    end

    assign a_out_data = a_pipe_q[RD_LATENCY-2];
    assign a_out_vld  = vld_pipe_q[RD_LATENCY-2];
    assign a_out_last = last_pipe_q[RD_LATENCY-2];
    assign comp_dout  = b_pipe_q[RD_LATENCY-2];
  end

endmodule

`default_nettype wire
